// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port unified instruction/data memory between the fetch
// stage and the memory stage. One memory transaction is in flight at a time.
// Address, write enable and write data are captured at grant and held stable
// for the whole transaction; read data is registered per requester.
//
// Optional feature (compile-time macro): MEM_ARB_STARVE_GUARD_EN
//   When defined, a counter tracks data grants taken while fetch is waiting.
//   Once it reaches STARVE_LIMIT, the next IDLE decision goes to fetch even
//   if a data request is pending. When undefined, data has strict priority
//   and no counter exists.
//
// Parameters:
//   ADDR_W        address width
//   DATA_W        data width
//   STARVE_LIMIT  data grants tolerated while fetch waits (guard build only)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   if_req     in   fetch read request, held until if_ready
//   if_addr    in   fetch address
//   if_ready   out  one-cycle pulse: fetch complete
//   if_rdata   out  registered fetch data
//   dm_req     in   data request, held until dm_ready
//   dm_we      in   1 = store, 0 = load
//   dm_addr    in   data address
//   dm_wdata   in   store data
//   dm_ready   out  one-cycle pulse: data access complete
//   dm_rdata   out  registered load data
//   mem_req    out  memory request, high for whole transaction
//   mem_we     out  memory write enable
//   mem_addr   out  registered memory address
//   mem_wdata  out  registered memory write data
//   mem_rdata  in   memory read data, valid with mem_ack
//   mem_ack    in   one-cycle completion pulse from memory
//   arb_busy   out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              arb_busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        RESP_IF = 3'd3,
        RESP_DM = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    // Grant decisions taken in IDLE; used by the FSM and by the starve counter.
    logic grant_if;
    logic grant_dm;
    // High when fetch must win over a pending data request.
    logic fetch_first;

    // A limit below one would make the guard override data on every request.
    if (STARVE_LIMIT < 1) begin : g_limit_invalid
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign fetch_first = if_req && (starve_q >= CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (grant_if) begin
            starve_d = '0;
        end else if (grant_dm && if_req) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict data priority: fetch never overrides a pending data request.
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_first) begin
                    grant_if = 1'b1;
                end else if (dm_req) begin
                    grant_dm = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end

                if (grant_dm) begin
                    state_d     = BUSY_DM;
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                end else if (grant_if) begin
                    // Write data is irrelevant for a fetch; leave it as is.
                    state_d    = BUSY_IF;
                    mem_addr_d = if_addr;
                    mem_we_d   = 1'b0;
                end
            end

            BUSY_IF: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    state_d    = RESP_IF;
                end
            end

            BUSY_DM: begin
                if (mem_ack) begin
                    // Stores complete without disturbing the last load result.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    state_d = RESP_DM;
                end
            end

            // The requester still holds its old request during the pulse,
            // so nothing is granted until the following IDLE cycle.
            RESP_IF: state_d = IDLE;
            RESP_DM: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    // The captured write enable outlives the transaction; only expose it
    // while the request is actually on the memory port.
    assign mem_we    = mem_we_q && mem_req;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = (state_q == RESP_IF);
    assign dm_ready  = (state_q == RESP_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. Each request is pushed to a queue in the
// order it is expected to be granted; a monitor checks every memory
// transaction and every ready pulse against the queue head. A small memory
// model acknowledges after a programmable number of wait states.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ready;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          arb_busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ready (dm_ready),
        .dm_rdata (dm_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .arb_busy (arb_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          len;
    } txn_t;

    txn_t sb[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    int          wait_states = 0;
    bit          ack_en      = 1'b1;
    bit          stray_ack   = 1'b0;
    int          ack_cnt     = 0;
    logic [31:0] last_load   = '0;

    // Memory model: ack after wait_states extra busy cycles.
    always @(negedge clk) begin
        if (mem_req && ack_en) begin
            mem_ack   = (ack_cnt == wait_states);
            mem_rdata = mem_fn(mem_addr);
            ack_cnt++;
        end else begin
            mem_ack   = stray_ack;
            mem_rdata = 32'hBADB_AD00;
            ack_cnt   = 0;
        end
    end

    // Monitor: checks grants and responses against the scoreboard head.
    bit   prev_req  = 1'b0;
    int   busy_len  = 0;
    bit   idle_next = 1'b0;
    txn_t mt;

    always @(negedge clk) begin
        if (rst) begin
            prev_req  = 1'b0;
            busy_len  = 0;
            idle_next = 1'b0;
        end else begin
            if (idle_next) begin
                check("idle_after_resp", arb_busy, 1'b0);
                idle_next = 1'b0;
            end
            if (mem_req) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", 1'b1, 1'b0);
                end else begin
                    if (!prev_req) begin
                        $display("grant %s addr=0x%08h we=%0d wdata=0x%08h",
                                 sb[0].is_dm ? "DM" : "IF", mem_addr, mem_we, mem_wdata);
                        check("grant_addr", mem_addr, sb[0].addr);
                        if (sb[0].we) check("grant_wdata", mem_wdata, sb[0].wdata);
                    end
                    check("busy_mem_we", mem_we, sb[0].we);
                    check("busy_flag", arb_busy, 1'b1);
                end
                busy_len++;
            end
            if (if_ready || dm_ready) begin
                check("mem_req_in_resp", mem_req, 1'b0);
                if (sb.size() == 0) begin
                    check("unexpected_ready", 1'b1, 1'b0);
                end else begin
                    mt = sb.pop_front();
                    $display("ready %s addr=0x%08h rdata=0x%08h busy=%0d",
                             mt.is_dm ? "DM" : "IF", mt.addr,
                             mt.is_dm ? dm_rdata : if_rdata, busy_len);
                    check("ready_port", {if_ready, dm_ready}, mt.is_dm ? 2'b01 : 2'b10);
                    check("ready_rdata", mt.is_dm ? dm_rdata : if_rdata, mt.rdata);
                    check("busy_len", busy_len, mt.len);
                end
                busy_len  = 0;
                idle_next = 1'b1;
            end
            prev_req = mem_req;
        end
    end

    task automatic push(input bit is_dm, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        txn_t t;
        t.is_dm = is_dm;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        if (is_dm && we) begin
            t.rdata = last_load;
        end else begin
            t.rdata = mem_fn(addr);
            if (is_dm) last_load = t.rdata;
        end
        t.len = wait_states + 1;
        sb.push_back(t);
    endtask

    // Call at a negedge. Holds if_req until if_ready is seen.
    task automatic do_fetch(input logic [31:0] addr, input bit lat_chk);
        bit got = 1'b0;
        if_req  = 1'b1;
        if_addr = addr;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (lat_chk && i == 0) check("lat_mem_req", mem_req, 1'b1);
            if (if_ready) begin
                got = 1'b1;
                if (lat_chk) check("lat_if_ready", i, 1);
            end
        end
        if (!got) check("fetch_timeout", 1'b0, 1'b1);
        if_req = 1'b0;
    endtask

    // Call at a negedge. Issues n accesses back to back, dm_req held throughout.
    task automatic do_data(input int n, input bit we, input logic [31:0] base,
                           input logic [31:0] wbase);
        bit got;
        for (int k = 0; k < n; k++) begin
            got      = 1'b0;
            dm_req   = 1'b1;
            dm_we    = we;
            dm_addr  = base + 32'(4 * k);
            dm_wdata = wbase + 32'(k);
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (dm_ready) got = 1'b1;
            end
            if (!got) check("data_timeout", 1'b0, 1'b1);
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_ready"}, if_ready, 1'b0);
        check({tag, "_dm_ready"}, dm_ready, 1'b0);
        check({tag, "_if_rdata"}, if_rdata, 32'h0);
        check({tag, "_dm_rdata"}, dm_rdata, 32'h0);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_arb_busy"}, arb_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        bit  seen;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait fetch with latency checks.
        wait_states = 0;
        push(1'b0, 1'b0, 32'h10, 32'h0);
        do_fetch(32'h10, 1'b1);
        @(negedge clk);

        // Contention: data wins, fetch follows.
        push(1'b1, 1'b0, 32'h200, 32'h0);
        push(1'b0, 1'b0, 32'h24, 32'h0);
        fork
            do_data(1, 1'b0, 32'h200, 32'h0);
            do_fetch(32'h24, 1'b0);
        join
        @(negedge clk);

        // Fetch with two wait states.
        wait_states = 2;
        push(1'b0, 1'b0, 32'h80, 32'h0);
        do_fetch(32'h80, 1'b0);
        @(negedge clk);

        // Store with three wait states; load data must survive.
        wait_states = 3;
        push(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        do_data(1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        check("store_keeps_dm_rdata", dm_rdata, mem_fn(32'h200));
        @(negedge clk);

        // Back-to-back zero-wait loads: one access per three cycles.
        wait_states = 0;
        for (int k = 0; k < 3; k++) push(1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'h0);
        t0 = $time;
        do_data(3, 1'b0, 32'h300, 32'h0);
        check("b2b_cycles", ($time - t0) / 10, 8);
        @(negedge clk);

        // Reset during BUSY_IF, then a late ack.
        ack_en = 1'b0;
        push(1'b0, 1'b0, 32'h50, 32'h0);
        if_req  = 1'b1;
        if_addr = 32'h50;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        check("rst_test_busy", seen, 1'b1);
        @(negedge clk);
        rst    = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        last_load = '0;
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_no_ready", {if_ready, dm_ready}, 2'b00);
        end
        check("late_ack_if_rdata", if_rdata, 32'h0);
        check("late_ack_idle", arb_busy, 1'b0);
        ack_en = 1'b1;

        // Recovery after reset.
        wait_states = 1;
        push(1'b0, 1'b0, 32'h60, 32'h0);
        do_fetch(32'h60, 1'b0);
        @(negedge clk);

        // Starvation: four held data accesses against a held fetch.
        wait_states = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        push(1'b1, 1'b0, 32'h400, 32'h0);
        push(1'b1, 1'b0, 32'h404, 32'h0);
        push(1'b0, 1'b0, 32'h70, 32'h0);
        push(1'b1, 1'b0, 32'h408, 32'h0);
        push(1'b1, 1'b0, 32'h40C, 32'h0);
`else
        for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'h0);
        push(1'b0, 1'b0, 32'h70, 32'h0);
`endif
        fork
            do_data(4, 1'b0, 32'h400, 32'h0);
            do_fetch(32'h70, 1'b0);
        join
        repeat (2) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
